// File: rtl/rb_stream_ctrl_pkg.sv
// Shared types, defaults and width helper for the row-buffer stream controller.
package rb_stream_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FILL  = 3'd1,
      ST_RW    = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam int DEF_IMG_W = 8;
   localparam int DEF_IMG_H = 8;
   localparam int DEF_K     = 3;

   // Counter/address width; never narrower than one bit.
   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/rb_stream_ctrl_ring_ptr.sv
// Ring position counters: BRAM pointer, column within row and row bank.
// Zero latency to outputs; advances only on inc, so stalls simply hold position.
module rb_stream_ctrl_ring_ptr
   import rb_stream_ctrl_pkg::*;
#(
   parameter int IMG_W = DEF_IMG_W,
   parameter int K     = DEF_K,
   localparam int DEPTH = (K - 1) * IMG_W,
   localparam int AW    = clog2_min1(DEPTH),
   localparam int BW    = clog2_min1(K - 1),
   localparam int CW    = clog2_min1(IMG_W)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   output logic [AW-1:0] ptr,
   output logic [CW-1:0] col,
   output logic [BW-1:0] bank,
   output logic          ptr_wrap
);

   logic col_wrap;
   logic bank_wrap;

   assign ptr_wrap  = (ptr == AW'(DEPTH - 1));
   assign col_wrap  = (col == CW'(IMG_W - 1));
   assign bank_wrap = (bank == BW'(K - 2));

   // Pointer and bank wrap on the same inc because DEPTH is a whole number of rows.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         ptr  <= '0;
         col  <= '0;
         bank <= '0;
      end else if (inc) begin
         ptr <= ptr_wrap ? '0 : ptr + 1'b1;
         col <= col_wrap ? '0 : col + 1'b1;
         if (col_wrap)
            bank <= bank_wrap ? '0 : bank + 1'b1;
      end
   end

endmodule

// File: rtl/rb_stream_ctrl.sv
// Row-buffer controller: fills a (K-1)-row BRAM ring, then read-before-overwrite per pixel.
// Output valid one cycle after an RW accept; a stalled output blocks input and holds BRAM port B.
module rb_stream_ctrl
   import rb_stream_ctrl_pkg::*;
#(
   parameter int IMG_W = DEF_IMG_W,
   parameter int IMG_H = DEF_IMG_H,
   parameter int K     = DEF_K,
   localparam int DEPTH = (K - 1) * IMG_W,
   localparam int AW    = clog2_min1(DEPTH),
   localparam int BW    = clog2_min1(K - 1),
   localparam int CW    = clog2_min1(IMG_W)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          in_valid,
   output logic          in_ready,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic          rd_en,
   output logic [AW-1:0] rd_addr,
   output logic [BW-1:0] steer,
   output logic          steer_en,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [CW-1:0] out_col,
   output logic          busy,
   output logic          complete
);

   localparam int TOTAL = IMG_W * IMG_H;
   localparam int PW    = clog2_min1(TOTAL);

   state_t        state;
   logic [PW-1:0] pix_cnt;
   logic [AW-1:0] ptr;
   logic [CW-1:0] col;
   logic [BW-1:0] bank;
   logic          ptr_wrap;
   logic          acc;
   logic          last_pix;

   rb_stream_ctrl_ring_ptr #(
      .IMG_W (IMG_W),
      .K     (K)
   ) u_ring_ptr (
      .clk      (clk),
      .rst      (rst),
      .clr      (start),
      .inc      (acc),
      .ptr      (ptr),
      .col      (col),
      .bank     (bank),
      .ptr_wrap (ptr_wrap)
   );

   // A start or reset cycle never consumes a pixel, so the source address stays in step.
   always_comb begin
      in_ready = 1'b0;
      case (state)
         ST_FILL: in_ready = 1'b1;
         ST_RW:   in_ready = !out_valid || out_ready;
         default: in_ready = 1'b0;
      endcase
      if (rst || start)
         in_ready = 1'b0;
   end

   assign acc      = in_valid && in_ready;
   assign wr_en    = acc;
   assign rd_en    = acc && (state == ST_RW);
   assign steer_en = rd_en;
   assign wr_addr  = wr_en ? ptr : '0;
   assign rd_addr  = rd_en ? ptr : '0;
   assign steer    = steer_en ? bank : '0;
   assign last_pix = (pix_cnt == PW'(TOTAL - 1));

   assign busy     = (state == ST_FILL) || (state == ST_RW) || (state == ST_DRAIN);
   assign complete = (state == ST_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         pix_cnt   <= '0;
         out_valid <= 1'b0;
         out_col   <= '0;
      end else if (start) begin
         state     <= ST_FILL;
         pix_cnt   <= '0;
         out_valid <= 1'b0;
         out_col   <= '0;
      end else begin
         if (acc)
            pix_cnt <= last_pix ? '0 : pix_cnt + 1'b1;

         // Port B data lands one cycle after rd_en; the column rides with it.
         if (rd_en) begin
            out_valid <= 1'b1;
            out_col   <= col;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         case (state)
            ST_FILL:  if (acc && ptr_wrap) state <= ST_RW;
            ST_RW:    if (acc && last_pix) state <= ST_DRAIN;
            ST_DRAIN: if (!out_valid || out_ready) state <= ST_DONE;
            default:  state <= state;
         endcase
      end
   end

endmodule
